iigs_shadow_wq: RTL

Parametrised shadow write queue for the IIgs memory system. Captures CPU writes to shadowed video regions of the fast banks (00/01 by default) and replays them into the 1 MHz slow RAM (E0/E1) through a buffered, rate-limited request/acknowledge port. It stalls the CPU only on a full queue or an ordering hazard. It generalises the combinational shadow decode: a configurable bank pair, queue depth, slot rate, and write coalescing.

---
 rtl/iigs_shadow_wq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/iigs_shadow_wq.sv
// rtl/iigs_shadow_wq.sv - shadowed video write queue replaying fast-bank writes into slow RAM
module iigs_shadow_wq #(
    parameter int         DEPTH    = 8,
    parameter int         SLOW_DIV = 14,
    parameter logic [7:0] SRC_BANK = 8'h00,
    parameter logic [7:0] DST_BANK = 8'he0
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     cpu_ce,
    input  logic [7:0]               bank,
    input  logic [15:0]              addr,
    input  logic [7:0]               dout,
    input  logic                     we,
    input  logic                     IO,
    input  logic [7:0]               shadow,
    output logic                     cpu_stall,
    output logic                     slow_req,
    output logic [16:0]              slow_addr,
    output logic [7:0]               slow_data,
    input  logic                     slow_ack,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(SLOW_DIV);
    localparam logic [7:0]    SRC_AUX  = SRC_BANK + 8'd1;
    localparam logic [7:0]    DST_AUX  = DST_BANK + 8'd1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOW_DIV - 1);

    typedef enum logic {IDLE, REQ} state_t;

    // entry layout: {bank lsb, addr[15:0], data[7:0]}
    logic [24:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, tail_idx;
    logic [CW-1:0] cnt;
    state_t        state, state_d;
    logic          issue, pop, full, push, coalesce, cap, in_flight;
    logic          main_b, aux_b, txt1, txt2, hgr1, hgr2, shr, src_hit, dst_hit;
    logic          unused_bits;

    assign unused_bits = ^shadow[7:6];

    assign main_b = (bank == SRC_BANK);
    assign aux_b  = (bank == SRC_AUX);
    assign txt1   = (addr[15:10] == 6'b000001) & ~shadow[0];
    assign txt2   = (addr[15:10] == 6'b000010) & ~shadow[5];
    assign hgr1   = (addr[15:13] == 3'b001) & ~shadow[1];
    assign hgr2   = (addr[15:13] == 3'b010) & ~shadow[2];
    // super-hires lives only in the aux bank and is not gated by the aux inhibit bit
    assign shr    = aux_b & (addr >= 16'h2000) & (addr <= 16'h9fff) & ~shadow[3];
    assign src_hit = ~IO & (((txt1 | txt2 | hgr1 | hgr2) & (main_b | (aux_b & ~shadow[4]))) | shr);
    assign dst_hit = ~IO & ((bank == DST_BANK) | (bank == DST_AUX));

    assign full      = (level == FULL_LVL);
    assign cpu_stall = reset & (full | (dst_hit & (level != '0)));
    assign slow_req  = (state == REQ);

    assign cap       = cpu_ce & we & src_hit;
    assign tail_idx  = wr_ptr - AW'(1);
    // the head being issued this cycle counts as in flight: its data is already latched out
    assign in_flight = (state == REQ) | issue;
    assign coalesce  = cap & ~full & (level != '0) &
                       (mem[tail_idx][24:8] == {bank[0], addr}) &
                       ~(in_flight & (level == LW'(1)));
    assign push      = cap & ~full & ~coalesce;

    always_comb begin
        state_d = state;
        issue   = 1'b0;
        pop     = 1'b0;
        case (state)
            IDLE: if (cnt == '0 && level != '0) begin
                state_d = REQ;
                issue   = 1'b1;
            end
            REQ: if (slow_ack) begin
                state_d = IDLE;
                pop     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            slow_addr <= '0;
            slow_data <= '0;
        end else begin
            state <= state_d;
            cnt   <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (cap & full)
                overflow <= 1'b1;
            if (issue) begin
                slow_addr <= mem[rd_ptr][24:8];
                slow_data <= mem[rd_ptr][7:0];
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            if (push)
                mem[wr_ptr] <= {bank[0], addr, dout};
            else if (coalesce)
                mem[tail_idx][7:0] <= dout;
        end
    end
endmodule
